// File: rtl/ham_secded_decoder_if.sv
// Handshake bundle between a code-word source, the SECDED decoder and its consumer.
interface ham_secded_decoder_if #(
  parameter int unsigned PAR_W  = 3,
  parameter int unsigned SECDED = 1
);
  localparam int unsigned N  = (1 << PAR_W) - 1;
  localparam int unsigned CW = N + SECDED;
  localparam int unsigned K  = N - PAR_W;

  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_code;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_code;
  logic [K-1:0]     out_data;
  logic [PAR_W-1:0] out_syndrome;
  logic             out_corrected;
  logic             out_uncorr;

  // Source/consumer side
  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_code, out_data, out_syndrome, out_corrected, out_uncorr
  );

  // Decoder side
  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_code, out_data, out_syndrome, out_corrected, out_uncorr
  );
endinterface

// File: rtl/ham_secded_decoder.sv
// Two-stage pipelined Hamming / SECDED decoder with saturating error-event counters.
module ham_secded_decoder #(
  parameter int unsigned PAR_W  = 3,
  parameter int unsigned SECDED = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  ham_secded_decoder_if.slave bus,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count
);
  localparam int unsigned N   = (1 << PAR_W) - 1;
  localparam int unsigned CW  = N + SECDED;
  localparam int unsigned K   = N - PAR_W;
  localparam int unsigned PW1 = PAR_W + 1;

  // Position (1-based) of the idx-th data bit: idx-th non-power-of-two position.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned cnt;
    int unsigned res;
    cnt = 0;
    res = 1;
    for (int unsigned p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

  logic             w_s1_load;
  logic             w_s2_load;
  logic             w_in_ready;
  logic             w_out_hs;
  logic [PAR_W-1:0] w_syn;
  logic             w_par;

  logic             r_s1_valid;
  logic [CW-1:0]    r_s1_code;
  logic [PAR_W-1:0] r_s1_syn;
  logic             r_s1_par;

  logic [PW1-1:0]   w_pos;
  logic             w_flip_en;
  logic             w_corr;
  logic             w_uncorr;
  logic [CW-1:0]    w_code;
  logic [K-1:0]     w_data;

  logic             r_s2_valid;
  logic [CW-1:0]    r_out_code;
  logic [K-1:0]     r_out_data;
  logic [PAR_W-1:0] r_out_syn;
  logic             r_out_corr;
  logic             r_out_uncorr;

  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;

  // Pipeline advance: stage 2 drains or is empty, stage 1 follows.
  assign w_s2_load  = !r_s2_valid || bus.out_ready;
  assign w_s1_load  = !r_s1_valid || w_s2_load;
  assign w_in_ready = w_s1_load && !rst;
  assign w_out_hs   = r_s2_valid && bus.out_ready;

  // Syndrome: each bit XORs the positions whose index has that bit set; plus overall parity.
  always_comb begin
    w_syn = '0;
    for (int unsigned p = 1; p <= N; p++) begin
      for (int unsigned j = 0; j < PAR_W; j++) begin
        if (((p >> j) & 1) != 0) w_syn[j] = w_syn[j] ^ bus.in_code[p-1];
      end
    end
    w_par = (SECDED != 0) ? ^bus.in_code : 1'b0;
  end

  // Stage 1: capture the accepted word with its syndrome and parity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_code <= bus.in_code;
        r_s1_syn  <= w_syn;
        r_s1_par  <= w_par;
      end
    end
  end

  // Classify the error and build the corrected word; S=0 with bad parity hits overall bit N.
  always_comb begin
    w_flip_en = 1'b0;
    w_uncorr  = 1'b0;
    w_pos     = {1'b0, r_s1_syn};
    w_code    = r_s1_code;
    if (SECDED != 0) begin
      if (r_s1_par) begin
        w_flip_en = 1'b1;
        if (r_s1_syn == '0) w_pos = PW1'(N + 1);
      end else if (r_s1_syn != '0) begin
        w_uncorr = 1'b1;
      end
    end else if (r_s1_syn != '0) begin
      w_flip_en = 1'b1;
    end
    w_corr = w_flip_en;
    for (int unsigned i = 0; i < CW; i++) begin
      w_code[i] = r_s1_code[i] ^ (w_flip_en && (w_pos == PW1'(i + 1)));
    end
  end

  // Data extraction from the corrected word, lowest data position to LSB.
  for (genvar d = 0; d < K; d++) begin : g_data
    assign w_data[d] = w_code[data_pos(d) - 1];
  end

  // Stage 2: output registers, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid   <= 1'b0;
      r_out_code   <= '0;
      r_out_data   <= '0;
      r_out_syn    <= '0;
      r_out_corr   <= 1'b0;
      r_out_uncorr <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_code   <= w_code;
        r_out_data   <= w_data;
        r_out_syn    <= r_s1_syn;
        r_out_corr   <= w_corr;
        r_out_uncorr <= w_uncorr;
      end
    end
  end

  // Saturating event counters; clear wins over a same-cycle event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (cnt_clear) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      if (w_out_hs && r_out_corr && (r_corr_cnt != '1)) r_corr_cnt <= r_corr_cnt + CNT_W'(1);
      if (w_out_hs && r_out_uncorr && (r_uncorr_cnt != '1)) r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = r_s2_valid;
  assign bus.out_code      = r_out_code;
  assign bus.out_data      = r_out_data;
  assign bus.out_syndrome  = r_out_syn;
  assign bus.out_corrected = r_out_corr;
  assign bus.out_uncorr    = r_out_uncorr;
  assign corr_count        = r_corr_cnt;
  assign uncorr_count      = r_uncorr_cnt;
endmodule
